// File: rtl/motor_drive_channels.sv
// Multi-channel H-bridge drive: shared PWM counter and ramp prescaler, per-channel
// soft-start, reversal dead time, filtered overcurrent trip with retry and lockout.
module motor_drive_channels #(
   parameter int CHANNELS  = 2,
   parameter int DUTY_W    = 12,
   parameter int RAMP_STEP = 64,
   parameter int RAMP_DIV  = 10000,
   parameter int DEADTIME  = 100000,
   parameter int OC_FILTER = 16,
   parameter int COOLDOWN  = 5000000,
   parameter int MAX_RETRY = 3
) (
   input  logic                       CLK100MHZ,
   input  logic                       reset_n,
   input  logic [CHANNELS*DUTY_W-1:0] duty_cmd,
   input  logic [CHANNELS-1:0]        dir_cmd,
   input  logic [CHANNELS-1:0]        oc_n,
   input  logic                       fault_clear,
   output logic [CHANNELS-1:0]        pwm_en,
   output logic [2*CHANNELS-1:0]      dir_out,
   output logic [CHANNELS*DUTY_W-1:0] duty_applied,
   output logic [CHANNELS-1:0]        fault,
   output logic [CHANNELS-1:0]        locked
);

   localparam int                PWM_LAST_I  = 2**DUTY_W - 2;
   localparam logic [DUTY_W-1:0] PWM_LAST    = PWM_LAST_I[DUTY_W-1:0];
   localparam int                PRE_W       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int                PRE_LAST_I  = RAMP_DIV - 1;
   localparam logic [PRE_W-1:0]  PRE_LAST    = PRE_LAST_I[PRE_W-1:0];
   localparam int                STEP_I      = (RAMP_STEP > 2**DUTY_W - 1) ? 2**DUTY_W - 1 : RAMP_STEP;
   localparam logic [DUTY_W:0]   STEP        = STEP_I[DUTY_W:0];
   localparam int                TMR_MAX     = (DEADTIME > COOLDOWN) ? DEADTIME : COOLDOWN;
   localparam int                TMR_W       = $clog2(TMR_MAX + 1);
   localparam int                DEAD_LAST_I = DEADTIME - 1;
   localparam logic [TMR_W-1:0]  DEAD_LAST   = DEAD_LAST_I[TMR_W-1:0];
   localparam int                COOL_LAST_I = COOLDOWN - 1;
   localparam logic [TMR_W-1:0]  COOL_LAST   = COOL_LAST_I[TMR_W-1:0];
   localparam int                FLT_W       = $clog2(OC_FILTER + 1);
   localparam logic [FLT_W-1:0]  FLT_LIM     = OC_FILTER[FLT_W-1:0];
   localparam int                RTY_W       = $clog2(MAX_RETRY + 1);
   localparam logic [RTY_W-1:0]  RTY_LIM     = MAX_RETRY[RTY_W-1:0];

   typedef enum logic [2:0] {
      ST_DEAD,
      ST_RUN,
      ST_TRIP,
      ST_COOL,
      ST_LOCK
   } state_t;

   // Rise by at most STEP without passing the target; any decrease is immediate.
   function automatic logic [DUTY_W-1:0] ramp_toward(input logic [DUTY_W-1:0] cur,
                                                     input logic [DUTY_W-1:0] tgt);
      logic [DUTY_W:0] gap;
      logic [DUTY_W:0] sum;
      gap = '0;
      sum = '0;
      ramp_toward = tgt;
      if (tgt > cur) begin
         gap = {1'b0, tgt} - {1'b0, cur};
         if (gap > STEP) begin
            sum = {1'b0, cur} + STEP;
            ramp_toward = sum[DUTY_W-1:0];
         end
      end
   endfunction

   logic [DUTY_W-1:0] cnt_reg;
   logic [PRE_W-1:0]  pre_reg;
   logic              ramp_tick;

   assign ramp_tick = (pre_reg == PRE_LAST);

   always_ff @(posedge CLK100MHZ or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg <= '0;
         pre_reg <= '0;
      end else begin
         cnt_reg <= (cnt_reg == PWM_LAST) ? '0 : cnt_reg + DUTY_W'(1);
         pre_reg <= ramp_tick ? '0 : pre_reg + PRE_W'(1);
      end
   end

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [1:0]        sync_reg;
      logic [FLT_W-1:0]  filt_reg;
      state_t            state_reg, state_next;
      logic [TMR_W-1:0]  timer_reg, timer_next;
      logic [RTY_W-1:0]  retry_reg, retry_next, retry_inc;
      logic              dir_app_reg, dir_app_next;
      logic [DUTY_W-1:0] cmd;
      logic [DUTY_W-1:0] duty_reg, duty_next;
      logic              pwm_reg, pwm_next;
      logic [1:0]        dir_reg, dir_next;
      logic              fault_reg, fault_next;
      logic              locked_reg, locked_next;

      assign cmd       = duty_cmd[gi*DUTY_W +: DUTY_W];
      assign retry_inc = retry_reg + RTY_W'(1);

      // oc_n is asynchronous: two flops, idle high, then a saturating low-run counter.
      always_ff @(posedge CLK100MHZ or negedge reset_n) begin
         if (!reset_n) begin
            sync_reg <= 2'b11;
            filt_reg <= '0;
         end else begin
            sync_reg <= {sync_reg[0], oc_n[gi]};
            if (sync_reg[1])
               filt_reg <= '0;
            else if (filt_reg != FLT_LIM)
               filt_reg <= filt_reg + FLT_W'(1);
         end
      end

      always_ff @(posedge CLK100MHZ or negedge reset_n) begin
         if (!reset_n) begin
            state_reg   <= ST_DEAD;
            timer_reg   <= '0;
            retry_reg   <= '0;
            dir_app_reg <= 1'b0;
            duty_reg    <= '0;
            pwm_reg     <= 1'b0;
            dir_reg     <= 2'b00;
            fault_reg   <= 1'b0;
            locked_reg  <= 1'b0;
         end else begin
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            retry_reg   <= retry_next;
            dir_app_reg <= dir_app_next;
            duty_reg    <= duty_next;
            pwm_reg     <= pwm_next;
            dir_reg     <= dir_next;
            fault_reg   <= fault_next;
            locked_reg  <= locked_next;
         end
      end

      always_comb begin
         state_next   = state_reg;
         retry_next   = retry_reg;
         dir_app_next = dir_app_reg;
         case (state_reg)
            ST_DEAD: begin
               if (timer_reg == DEAD_LAST) begin
                  state_next   = ST_RUN;
                  dir_app_next = dir_cmd[gi];
               end
            end
            ST_RUN: begin
               // Overcurrent wins over a simultaneous reversal request.
               if (filt_reg == FLT_LIM)
                  state_next = ST_TRIP;
               else if (dir_cmd[gi] != dir_app_reg)
                  state_next = ST_DEAD;
            end
            ST_TRIP: begin
               retry_next = retry_inc;
               state_next = (retry_inc == RTY_LIM) ? ST_LOCK : ST_COOL;
            end
            ST_COOL: begin
               if (timer_reg == COOL_LAST)
                  state_next = ST_DEAD;
            end
            ST_LOCK: begin
               if (fault_clear) begin
                  state_next = ST_DEAD;
                  retry_next = '0;
               end
            end
            default: state_next = ST_DEAD;
         endcase
         // Timer restarts on every state change, so a reversal gets a full dead time.
         timer_next = '0;
         if (state_next == state_reg && (state_reg == ST_DEAD || state_reg == ST_COOL))
            timer_next = timer_reg + TMR_W'(1);
      end

      always_comb begin
         duty_next   = '0;
         pwm_next    = 1'b0;
         dir_next    = 2'b00;
         fault_next  = 1'b0;
         locked_next = 1'b0;
         case (state_reg)
            ST_RUN: begin
               duty_next = ramp_tick ? ramp_toward(duty_reg, cmd) : duty_reg;
               pwm_next  = (cnt_reg < duty_reg);
               dir_next  = dir_app_reg ? 2'b01 : 2'b10;
            end
            ST_TRIP: fault_next = 1'b1;
            ST_COOL: fault_next = 1'b1;
            ST_LOCK: begin
               fault_next  = 1'b1;
               locked_next = 1'b1;
            end
            default: ;
         endcase
      end

      assign pwm_en[gi]                        = pwm_reg;
      assign dir_out[2*gi +: 2]                = dir_reg;
      assign duty_applied[gi*DUTY_W +: DUTY_W] = duty_reg;
      assign fault[gi]                         = fault_reg;
      assign locked[gi]                        = locked_reg;
   end

endmodule
